dual_issue_scheduler: RTL and testbench
=======================================

# dual_issue_scheduler

Issue scheduler for the dual-issue pipeline. It sits between the IF/ID register and the ID/EX register and decides each cycle whether the fetched instruction pair issues together, issues split (slot 1 now, slot 2 next cycle), or waits a cycle. It is the only source of the PC/IF-ID hold signal for intra-pair dependencies and load-use hazards. It tracks loads in EX internally.

## Interface
Parameters:
- REG_W, 5, register-index width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  global pipeline enable. When low, all internal state holds.
- pair_valid  in  1  IF/ID holds a valid instruction pair.
- flush  in  1  redirect from EX. Cancels the pair currently in decode.
- rs1, rt1, dst1  in  REG_W each  slot-1 source registers and resolved write register (after RegDst).
- rs2, rt2, dst2  in  REG_W each  same fields for slot 2.
- uses_rt1, uses_rt2  in  1  the slot reads rt.
- reg_write1, reg_write2  in  1  the slot writes dst.
- mem_read1, mem_read2, mem_write1, mem_write2  in  1  the slot accesses data memory.
- ctrl_xfer1  in  1  slot 1 is a branch, jump or jr.
- issue1, issue2  out  1  valid bit into ID/EX lane 1 / lane 2.
- stall  out  1  hold PC and IF/ID.
- split  out  1  state == SPLIT.
- hazard_cause  out  3  reason for the current decision, encoded per issue_pkg.

## Operation
- States: PAIR and SPLIT. Reset state is PAIR.
- EX load tracker: two entries {valid, dst}, one per lane. On each enabled edge, entry k loads issue_k & mem_read_k & reg_write_k, together with dst_k.
- ld_hit(r) is true when r != 0 and r matches the dst of a valid tracker entry.
- A slot's sources are rs, plus rt when uses_rt is set.
- The pair conflicts when any of these holds:
  - RAW: reg_write1, dst1 != 0, and a slot-2 source equals dst1.
  - WAW: reg_write1, reg_write2, and dst1 == dst2 != 0.
  - MEM: slot 1 and slot 2 both access memory. There is a single data-memory port.
  - CTRL: ctrl_xfer1 is set. Slot 2 is in the shadow.
- PAIR with pair_valid, no flush:
  - ld_hit on any slot-1 source: issue none, stall=1, stay in PAIR.
  - Else, pair conflict or ld_hit on a slot-2 source: issue1=1, issue2=0, stall=1, go to SPLIT.
  - Else: issue1=issue2=1, stall=0.
- SPLIT, no flush:
  - ld_hit on a slot-2 source: issue none, stall=1, stay in SPLIT. Covers slot 1 being a load that slot 2 consumes.
  - Else: issue2=1 (lane 2), issue1=0, stall=0, go to PAIR.
- pair_valid=0 in PAIR: issue none, stall=0.
- flush, in any state and taking priority over everything: issue none, stall=0, next state PAIR. The tracker therefore captures no loads for that cycle.
- hazard_cause priority: LDUSE1 > RAW > WAW > MEM > CTRL > LDUSE2. Reports NONE when the pair issues fully, the pair is invalid, or flush is asserted. In SPLIT it reports LDUSE2 while waiting and SPLITISS when slot 2 issues.

## Timing
- issue1, issue2, stall and hazard_cause are combinational from inputs plus registered state (zero-cycle decision). split is registered.
- Reset values: state=PAIR, tracker entries invalid, split=0. With pair_valid=0 this gives issue1=issue2=stall=0 and hazard_cause=NONE.
- A load issued at edge N is compared against decode during cycle N+1 only. It causes at most a 1-cycle bubble.
- A split pair takes at least 2 cycles. Each load-use wait adds 1 cycle.
- enable=0: state and tracker hold. Outputs are still driven but are ignored downstream.
- rst asserted mid-SPLIT: the pending slot 2 is dropped. The state returns to PAIR immediately (asynchronous).

## Structure
- issue_pkg holds:
  - the state enum {PAIR, SPLIT};
  - hazard_cause codes: NONE=0, LDUSE1=1, RAW=2, WAW=3, MEM=4, CTRL=5, LDUSE2=6, SPLITISS=7.
- One combinational sub-module, pair_hazard_check. It takes the slot fields and the tracker contents and returns the conflict flags and both ld_hit results. The FSM and tracker stay in the top module.

## Test plan
- Independent pair (add $3,$1,$2 / sub $6,$4,$5) -> issue1=issue2=1, stall=0, cause=NONE, stays in PAIR.
- RAW pair (add $3,$1,$2 / or $7,$3,$4) -> cycle 0: issue1=1, stall=1, cause=RAW. Cycle 1: issue2=1, stall=0, back to PAIR.
- Pair lw $5,0($1) / add $6,$5,$2:
  - cycle 0: split with cause=RAW;
  - cycle 1: no issue, stall=1, cause=LDUSE2;
  - cycle 2: issue2=1.
- Previous cycle issued lw $8 in lane 2; current pair is add $9,$8,$0 / any -> no issue, stall=1, cause=LDUSE1. Next cycle the full pair issues.
- sw / lw pair -> split with cause=MEM. beq in slot 1 -> split with cause=CTRL. WAW pair with dst1=dst2=$4 -> cause=WAW. Pair whose only overlap is dst=$0 -> full issue.
- flush asserted while in SPLIT -> issue none, stall=0, state PAIR next edge. Separately, rst pulsed mid-SPLIT -> split=0 immediately, tracker cleared.

Source files
------------

// File: rtl/issue_pkg.sv
// issue_pkg: shared types for the dual-issue scheduler.
//   state_t - scheduler FSM states (PAIR, SPLIT)
//   cause_t - hazard_cause encodings driven on o_hazard_cause
package issue_pkg;

  typedef enum logic {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_LDUSE1   = 3'd1,
    CAUSE_RAW      = 3'd2,
    CAUSE_WAW      = 3'd3,
    CAUSE_MEM      = 3'd4,
    CAUSE_CTRL     = 3'd5,
    CAUSE_LDUSE2   = 3'd6,
    CAUSE_SPLITISS = 3'd7
  } cause_t;

endpackage

// File: rtl/pair_hazard_check.sv
// pair_hazard_check: combinational intra-pair conflict and load-use detection.
// Inputs : slot-1/slot-2 register fields and control bits, plus the two
//          EX load-tracker entries {valid, dst}.
// Outputs: o_raw, o_waw, o_mem, o_ctrl  - pair conflict flags
//          o_ldhit1, o_ldhit2           - a slot source hits an in-flight load
module pair_hazard_check
  import issue_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rt1,
  input  logic [REG_W-1:0] i_dst1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic [REG_W-1:0] i_rt2,
  input  logic [REG_W-1:0] i_dst2,
  input  logic             i_uses_rt1,
  input  logic             i_uses_rt2,
  input  logic             i_reg_write1,
  input  logic             i_reg_write2,
  input  logic             i_mem_acc1,
  input  logic             i_mem_acc2,
  input  logic             i_ctrl_xfer1,
  input  logic             i_trk_v0,
  input  logic [REG_W-1:0] i_trk_d0,
  input  logic             i_trk_v1,
  input  logic [REG_W-1:0] i_trk_d1,
  output logic             o_raw,
  output logic             o_waw,
  output logic             o_mem,
  output logic             o_ctrl,
  output logic             o_ldhit1,
  output logic             o_ldhit2
);

  // $0 is hardwired zero, so a load "to $0" never creates a dependency.
  function automatic logic ld_hit(input logic [REG_W-1:0] r,
                                  input logic v0, input logic [REG_W-1:0] d0,
                                  input logic v1, input logic [REG_W-1:0] d1);
    return (r != '0) && ((v0 && (r == d0)) || (v1 && (r == d1)));
  endfunction

  logic w_dst1_nz;

  assign w_dst1_nz = (i_dst1 != '0);

  assign o_raw  = i_reg_write1 && w_dst1_nz &&
                  ((i_rs2 == i_dst1) || (i_uses_rt2 && (i_rt2 == i_dst1)));
  assign o_waw  = i_reg_write1 && i_reg_write2 && w_dst1_nz && (i_dst1 == i_dst2);
  assign o_mem  = i_mem_acc1 && i_mem_acc2;
  assign o_ctrl = i_ctrl_xfer1;

  assign o_ldhit1 = ld_hit(i_rs1, i_trk_v0, i_trk_d0, i_trk_v1, i_trk_d1) ||
                    (i_uses_rt1 && ld_hit(i_rt1, i_trk_v0, i_trk_d0, i_trk_v1, i_trk_d1));
  assign o_ldhit2 = ld_hit(i_rs2, i_trk_v0, i_trk_d0, i_trk_v1, i_trk_d1) ||
                    (i_uses_rt2 && ld_hit(i_rt2, i_trk_v0, i_trk_d0, i_trk_v1, i_trk_d1));

endmodule

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: decides per cycle whether the decoded instruction pair
// issues together, splits (slot 1 now, slot 2 next), or waits on a load.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   i_enable                 - global pipeline enable (state/tracker hold when low)
//   i_pair_valid, i_flush    - IF/ID pair valid, redirect from EX
//   i_rs*/i_rt*/i_dst*       - slot register fields
//   i_uses_rt*, i_reg_write*, i_mem_read*, i_mem_write*, i_ctrl_xfer1
//   o_issue1, o_issue2       - ID/EX lane valids
//   o_stall                  - hold PC and IF/ID
//   o_split                  - registered state == SPLIT
//   o_hazard_cause           - cause_t code for the current decision
module dual_issue_scheduler
  import issue_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_pair_valid,
  input  logic             i_flush,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rt1,
  input  logic [REG_W-1:0] i_dst1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic [REG_W-1:0] i_rt2,
  input  logic [REG_W-1:0] i_dst2,
  input  logic             i_uses_rt1,
  input  logic             i_uses_rt2,
  input  logic             i_reg_write1,
  input  logic             i_reg_write2,
  input  logic             i_mem_read1,
  input  logic             i_mem_read2,
  input  logic             i_mem_write1,
  input  logic             i_mem_write2,
  input  logic             i_ctrl_xfer1,
  output logic             o_issue1,
  output logic             o_issue2,
  output logic             o_stall,
  output logic             o_split,
  output logic [2:0]       o_hazard_cause
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_trk_v0;
  logic [REG_W-1:0] r_trk_d0;
  logic             r_trk_v1;
  logic [REG_W-1:0] r_trk_d1;

  logic   w_raw, w_waw, w_mem, w_ctrl, w_ldhit1, w_ldhit2;
  logic   w_issue1, w_issue2, w_stall;
  cause_t w_cause;

  pair_hazard_check #(.REG_W(REG_W)) u_check (
    .i_rs1       (i_rs1),
    .i_rt1       (i_rt1),
    .i_dst1      (i_dst1),
    .i_rs2       (i_rs2),
    .i_rt2       (i_rt2),
    .i_dst2      (i_dst2),
    .i_uses_rt1  (i_uses_rt1),
    .i_uses_rt2  (i_uses_rt2),
    .i_reg_write1(i_reg_write1),
    .i_reg_write2(i_reg_write2),
    .i_mem_acc1  (i_mem_read1 | i_mem_write1),
    .i_mem_acc2  (i_mem_read2 | i_mem_write2),
    .i_ctrl_xfer1(i_ctrl_xfer1),
    .i_trk_v0    (r_trk_v0),
    .i_trk_d0    (r_trk_d0),
    .i_trk_v1    (r_trk_v1),
    .i_trk_d1    (r_trk_d1),
    .o_raw       (w_raw),
    .o_waw       (w_waw),
    .o_mem       (w_mem),
    .o_ctrl      (w_ctrl),
    .o_ldhit1    (w_ldhit1),
    .o_ldhit2    (w_ldhit2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= PAIR;
      r_trk_v0 <= 1'b0;
      r_trk_d0 <= '0;
      r_trk_v1 <= 1'b0;
      r_trk_d1 <= '0;
    end else if (i_enable) begin
      r_state  <= w_state_next;
      r_trk_v0 <= w_issue1 & i_mem_read1 & i_reg_write1;
      r_trk_d0 <= i_dst1;
      r_trk_v1 <= w_issue2 & i_mem_read2 & i_reg_write2;
      r_trk_d1 <= i_dst2;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue1     = 1'b0;
    w_issue2     = 1'b0;
    w_stall      = 1'b0;
    w_cause      = CAUSE_NONE;
    if (i_flush) begin
      w_state_next = PAIR;
    end else begin
      unique case (r_state)
        PAIR: begin
          if (i_pair_valid) begin
            if (w_ldhit1) begin
              w_stall = 1'b1;
              w_cause = CAUSE_LDUSE1;
            end else if (w_raw || w_waw || w_mem || w_ctrl || w_ldhit2) begin
              w_issue1     = 1'b1;
              w_stall      = 1'b1;
              w_state_next = SPLIT;
              if (w_raw)       w_cause = CAUSE_RAW;
              else if (w_waw)  w_cause = CAUSE_WAW;
              else if (w_mem)  w_cause = CAUSE_MEM;
              else if (w_ctrl) w_cause = CAUSE_CTRL;
              else             w_cause = CAUSE_LDUSE2;
            end else begin
              w_issue1 = 1'b1;
              w_issue2 = 1'b1;
            end
          end
        end
        SPLIT: begin
          // Slot 2 waits here when it consumes a load issued on the previous edge,
          // including the case where that load was slot 1 of this same pair.
          if (w_ldhit2) begin
            w_stall = 1'b1;
            w_cause = CAUSE_LDUSE2;
          end else begin
            w_issue2     = 1'b1;
            w_cause      = CAUSE_SPLITISS;
            w_state_next = PAIR;
          end
        end
        default: w_state_next = PAIR;
      endcase
    end
  end

  assign o_issue1       = w_issue1;
  assign o_issue2       = w_issue2;
  assign o_stall        = w_stall;
  assign o_split        = (r_state == SPLIT);
  assign o_hazard_cause = w_cause;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb_dual_issue_scheduler: directed self-checking bench for dual_issue_scheduler.
// Inputs change just after each falling edge; outputs are checked 2 time units
// later, well clear of the rising edge.
module tb_dual_issue_scheduler;
  import issue_pkg::*;

  logic       clk, rst, en, pv, flush;
  logic [4:0] rs1, rt1, dst1, rs2, rt2, dst2;
  logic       urt1, urt2, rw1, rw2, mr1, mr2, mw1, mw2, cx1;
  logic       issue1, issue2, stall, split;
  logic [2:0] cause;

  int unsigned n_chk;
  int unsigned n_fail;

  dual_issue_scheduler #(.REG_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (en),
    .i_pair_valid  (pv),
    .i_flush       (flush),
    .i_rs1         (rs1),
    .i_rt1         (rt1),
    .i_dst1        (dst1),
    .i_rs2         (rs2),
    .i_rt2         (rt2),
    .i_dst2        (dst2),
    .i_uses_rt1    (urt1),
    .i_uses_rt2    (urt2),
    .i_reg_write1  (rw1),
    .i_reg_write2  (rw2),
    .i_mem_read1   (mr1),
    .i_mem_read2   (mr2),
    .i_mem_write1  (mw1),
    .i_mem_write2  (mw2),
    .i_ctrl_xfer1  (cx1),
    .o_issue1      (issue1),
    .o_issue2      (issue2),
    .o_stall       (stall),
    .o_split       (split),
    .o_hazard_cause(cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic e1, input logic e2,
                     input logic est, input logic esp, input logic [2:0] ec);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {issue1, issue2, stall, split, cause};
    exp = {e1, e2, est, esp, ec};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed i1,i2,stall,split,cause=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set1(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic ut, input logic w, input logic r, input logic m,
                      input logic c);
    rs1 = s; rt1 = t; dst1 = d; urt1 = ut; rw1 = w; mr1 = r; mw1 = m; cx1 = c;
  endtask

  task automatic set2(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic ut, input logic w, input logic r, input logic m);
    rs2 = s; rt2 = t; dst2 = d; urt2 = ut; rw2 = w; mr2 = r; mw2 = m;
  endtask

  // Instruction shorthands: R-type rd,rs,rt / lw rt,0(base) / sw rt,0(base) / beq
  task automatic r1(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    set1(s, t, d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic lw1(input logic [4:0] t, input logic [4:0] b);
    set1(b, 5'd0, t, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic sw1(input logic [4:0] t, input logic [4:0] b);
    set1(b, t, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic beq1(input logic [4:0] s, input logic [4:0] t);
    set1(s, t, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic r2(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    set2(s, t, d, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic lw2(input logic [4:0] t, input logic [4:0] b);
    set2(b, 5'd0, t, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic sw2(input logic [4:0] t, input logic [4:0] b);
    set2(b, t, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; en = 1'b1; pv = 1'b0; flush = 1'b0;
    set1(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set2(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("reset", 0, 0, 0, 0, CAUSE_NONE);
    step; rst = 1'b0;

    // Independent pair
    pv = 1'b1; r1(3, 1, 2); r2(6, 4, 5);
    #2 chk("indep", 1, 1, 0, 0, CAUSE_NONE);
    step; pv = 1'b0;
    #2 chk("indep_stay_pair", 0, 0, 0, 0, CAUSE_NONE);

    // RAW pair
    step; pv = 1'b1; r1(3, 1, 2); r2(7, 3, 4);
    #2 chk("raw_c0", 1, 0, 1, 0, CAUSE_RAW);
    step;
    #2 chk("raw_c1", 0, 1, 0, 1, CAUSE_SPLITISS);
    step; pv = 1'b0;
    #2 chk("raw_back_pair", 0, 0, 0, 0, CAUSE_NONE);

    // lw $5 / add $6,$5,$2
    step; pv = 1'b1; lw1(5, 1); r2(6, 5, 2);
    #2 chk("lwuse_c0", 1, 0, 1, 0, CAUSE_RAW);
    step;
    #2 chk("lwuse_c1", 0, 0, 1, 1, CAUSE_LDUSE2);
    step;
    #2 chk("lwuse_c2", 0, 1, 0, 1, CAUSE_SPLITISS);

    // Load in lane 2 feeding next slot 1
    step; r1(10, 11, 12); lw2(8, 13);
    #2 chk("ld_lane2_issue", 1, 1, 0, 0, CAUSE_NONE);
    step; r1(9, 8, 0); r2(14, 15, 16);
    #2 chk("lduse1_wait", 0, 0, 1, 0, CAUSE_LDUSE1);
    step;
    #2 chk("lduse1_release", 1, 1, 0, 0, CAUSE_NONE);

    // Load in lane 2 feeding next slot 2 only
    step; r1(10, 11, 12); lw2(8, 13);
    #2 chk("ld_lane2_again", 1, 1, 0, 0, CAUSE_NONE);
    step; r1(10, 11, 12); r2(13, 8, 1);
    #2 chk("lduse2_split", 1, 0, 1, 0, CAUSE_LDUSE2);
    step;
    #2 chk("lduse2_splitiss", 0, 1, 0, 1, CAUSE_SPLITISS);

    // sw / lw -> MEM
    step; sw1(2, 1); lw2(3, 4);
    #2 chk("mem_c0", 1, 0, 1, 0, CAUSE_MEM);
    step;
    #2 chk("mem_c1", 0, 1, 0, 1, CAUSE_SPLITISS);

    // beq in slot 1 -> CTRL
    step; beq1(1, 2); r2(6, 4, 5);
    #2 chk("ctrl_c0", 1, 0, 1, 0, CAUSE_CTRL);
    step;
    #2 chk("ctrl_c1", 0, 1, 0, 1, CAUSE_SPLITISS);

    // WAW on $4
    step; r1(4, 1, 2); r2(4, 5, 6);
    #2 chk("waw_c0", 1, 0, 1, 0, CAUSE_WAW);
    step;
    #2 chk("waw_c1", 0, 1, 0, 1, CAUSE_SPLITISS);

    // $0 overlaps are not dependencies
    step; r1(0, 1, 2); r2(0, 0, 3);
    #2 chk("zero_overlap", 1, 1, 0, 0, CAUSE_NONE);
    step; lw1(0, 1); r2(6, 4, 5);
    #2 chk("lw_zero_issue", 1, 1, 0, 0, CAUSE_NONE);
    step; r1(7, 0, 0); r2(9, 0, 10);
    #2 chk("lw_zero_no_hit", 1, 1, 0, 0, CAUSE_NONE);

    // RAW + MEM together: RAW wins, then load-use wait in SPLIT
    step; lw1(5, 1); sw2(5, 2);
    #2 chk("prio_raw_mem", 1, 0, 1, 0, CAUSE_RAW);
    step;
    #2 chk("prio_ldwait", 0, 0, 1, 1, CAUSE_LDUSE2);
    step;
    #2 chk("prio_splitiss", 0, 1, 0, 1, CAUSE_SPLITISS);

    // Flush while in SPLIT, then flush in PAIR
    step; r1(3, 1, 2); r2(7, 3, 4);
    #2 chk("flush_pre", 1, 0, 1, 0, CAUSE_RAW);
    step; flush = 1'b1;
    #2 chk("flush_in_split", 0, 0, 0, 1, CAUSE_NONE);
    step;
    #2 chk("flush_in_pair", 0, 0, 0, 0, CAUSE_NONE);
    step; flush = 1'b0; pv = 1'b0;
    #2 chk("flush_after", 0, 0, 0, 0, CAUSE_NONE);

    // enable low holds state
    step; pv = 1'b1; en = 1'b0;
    #2 chk("en0_c0", 1, 0, 1, 0, CAUSE_RAW);
    step;
    #2 chk("en0_hold_pair", 1, 0, 1, 0, CAUSE_RAW);
    step; en = 1'b1;
    #2 chk("en1_decide", 1, 0, 1, 0, CAUSE_RAW);
    step; en = 1'b0;
    #2 chk("en0_split", 0, 1, 0, 1, CAUSE_SPLITISS);
    step;
    #2 chk("en0_hold_split", 0, 1, 0, 1, CAUSE_SPLITISS);
    step; en = 1'b1;
    #2 chk("en1_splitiss", 0, 1, 0, 1, CAUSE_SPLITISS);
    step; pv = 1'b0;
    #2 chk("en1_back_pair", 0, 0, 0, 0, CAUSE_NONE);

    // Reset pulsed mid-SPLIT with a load in the tracker
    step; pv = 1'b1; lw1(5, 1); r2(6, 5, 2);
    #2 chk("rst_pre_c0", 1, 0, 1, 0, CAUSE_RAW);
    step;
    #2 chk("rst_pre_c1", 0, 0, 1, 1, CAUSE_LDUSE2);
    #1 rst = 1'b1; r1(7, 5, 1); r2(14, 15, 16);
    #1 chk("rst_async", 1, 1, 0, 0, CAUSE_NONE);
    step; rst = 1'b0;
    #2 chk("rst_released", 1, 1, 0, 0, CAUSE_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
